// File: rtl/scan_ctrl_2bit_pkg.sv
// Shared definitions for the digit scan controller: state codes, slice width, digit selector.
package scan_ctrl_2bit_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_BLANK  = 2'd2;

    localparam int unsigned SLICE_W = 4;
    localparam int unsigned NDIG    = 4;

    // Nibble for digit idx; idx*4 formed by concatenation to keep the base 4 bits wide.
    function automatic logic [SLICE_W-1:0] digit_sel(input logic [NDIG*SLICE_W-1:0] digits,
                                                     input logic [1:0] idx);
        return digits[{idx, 2'b00} +: SLICE_W];
    endfunction

endpackage

// File: rtl/scan_ctrl_2bit_rise_edge.sv
// One-flop rising-edge detector; pulse is high while d is high and was low last cycle.
module scan_ctrl_2bit_rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic q;

    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end

    assign pulse = d & ~q;

endmodule

// File: rtl/scan_ctrl_2bit.sv
// Digit scanner for a 2-to-4 one-hot decoder: cycles x with en, inserts blanking gaps,
// supports prescaled free-run and single-step modes, and registers the selected nibble.
module scan_ctrl_2bit
    import scan_ctrl_2bit_pkg::*;
#(
    parameter  int unsigned DIV   = 1000,
    parameter  int unsigned BLANK = 2,
    localparam int unsigned CW    = $clog2(DIV + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        mode,
    input  logic        step,
    input  logic [15:0] digits,
    output logic [1:0]  x,
    output logic        en,
    output logic [3:0]  nibble,
    output logic        wrap
);

    localparam int unsigned BW = $clog2(BLANK + 2);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] pre_q, pre_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          en_q, en_d;
    logic [3:0]    nibble_q;
    logic          wrap_q, wrap_d;
    logic          step_rise;
    logic          adv;

    scan_ctrl_2bit_rise_edge u_step_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (step),
        .pulse (step_rise)
    );

    // Next-state, counters and enable; run=0 wins over any pending advance.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        bcnt_d  = bcnt_q;
        idx_d   = idx_q;
        en_d    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_ACTIVE;
                    pre_d   = '0;
                    en_d    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else begin
                    en_d = 1'b1;
                    if (!mode) begin
                        if (pre_q == CW'(DIV - 1)) adv = 1'b1;
                        else                       pre_d = pre_q + CW'(1);
                    end else begin
                        adv = step_rise;
                    end
                    if (adv) begin
                        if (BLANK > 0) begin
                            state_d = ST_BLANK;
                            bcnt_d  = '0;
                            en_d    = 1'b0;
                        end else begin
                            idx_d = idx_q + 2'd1;
                            pre_d = '0;
                        end
                    end
                end
            end
            ST_BLANK: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (bcnt_q == BW'(BLANK - 1)) begin
                    state_d = ST_ACTIVE;
                    idx_d   = idx_q + 2'd1;
                    pre_d   = '0;
                    en_d    = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        wrap_d = (idx_q == 2'd3) && (idx_d == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pre_q    <= '0;
            bcnt_q   <= '0;
            idx_q    <= 2'd0;
            en_q     <= 1'b0;
            nibble_q <= 4'd0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            bcnt_q   <= bcnt_d;
            idx_q    <= idx_d;
            en_q     <= en_d;
            nibble_q <= digit_sel(digits, idx_d);
            wrap_q   <= wrap_d;
        end
    end

    // x is the index register itself, so x and idx can never disagree.
    assign x      = idx_q;
    assign en     = en_q;
    assign nibble = nibble_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_scan_ctrl_2bit.sv
// Randomised bench for scan_ctrl_2bit (DIV=4 with BLANK=2 and BLANK=0) against a behavioural model.
module tb_scan_ctrl_2bit;

    logic        clk = 1'b0;
    logic        rst, run, mode, step;
    logic [15:0] digits;
    logic [1:0]  x0, x1;
    logic        en0, en1, wrap0, wrap1;
    logic [3:0]  nib0, nib1;

    always #5 clk = ~clk;

    scan_ctrl_2bit #(.DIV(4), .BLANK(2)) u_dut0 (
        .clk(clk), .rst(rst), .run(run), .mode(mode), .step(step), .digits(digits),
        .x(x0), .en(en0), .nibble(nib0), .wrap(wrap0)
    );

    scan_ctrl_2bit #(.DIV(4), .BLANK(0)) u_dut1 (
        .clk(clk), .rst(rst), .run(run), .mode(mode), .step(step), .digits(digits),
        .x(x1), .en(en1), .nibble(nib1), .wrap(wrap1)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, obs, exp);
        end
    endtask

    // Model: running/lit flags, elapsed lit cycles, remaining gap cycles.
    typedef struct {
        int       idx;
        bit       running;
        bit       lit;
        int       cnt;
        int       gap;
        bit       sq;
        logic [3:0] nib;
        bit       wrap;
    } mdl_t;

    mdl_t m [2];

    function automatic mdl_t mstep(mdl_t s, bit r, bit rn, bit md, bit st,
                                   logic [15:0] dg, int dv, int bl);
        mdl_t n;
        bit   ev;
        bit   adv;
        bit   bump;
        n    = s;
        ev   = st && !s.sq;
        adv  = 1'b0;
        bump = 1'b0;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        n.wrap = 1'b0;
        if (!s.running) begin
            if (rn) begin
                n.running = 1'b1;
                n.lit     = 1'b1;
                n.cnt     = 0;
            end
        end else if (!rn) begin
            n.running = 1'b0;
        end else if (s.lit) begin
            if (!md) begin
                n.cnt = s.cnt + 1;
                adv   = (n.cnt >= dv);
            end else begin
                adv = ev;
            end
            if (adv) begin
                if (bl > 0) begin
                    n.lit = 1'b0;
                    n.gap = bl;
                end else begin
                    bump  = 1'b1;
                    n.cnt = 0;
                end
            end
        end else begin
            n.gap = s.gap - 1;
            if (n.gap == 0) begin
                bump  = 1'b1;
                n.lit = 1'b1;
                n.cnt = 0;
            end
        end
        if (bump) begin
            n.wrap = (n.idx == 3);
            n.idx  = (n.idx + 1) % 4;
        end
        n.sq  = st;
        n.nib = 4'((dg >> (4 * n.idx)) & 16'hF);
        return n;
    endfunction

    task automatic tick(input bit r, input bit rn, input bit md, input bit st, input logic [15:0] dg);
        rst    = r;
        run    = rn;
        mode   = md;
        step   = st;
        digits = dg;
        @(posedge clk);
        m[0] = mstep(m[0], r, rn, md, st, dg, 4, 2);
        m[1] = mstep(m[1], r, rn, md, st, dg, 4, 0);
        #1;
        cycle++;
        check("x_b2",      16'(x0),    16'(m[0].idx));
        check("en_b2",     16'(en0),   16'(m[0].running && m[0].lit));
        check("nibble_b2", 16'(nib0),  16'(m[0].nib));
        check("wrap_b2",   16'(wrap0), 16'(m[0].wrap));
        check("x_b0",      16'(x1),    16'(m[1].idx));
        check("en_b0",     16'(en1),   16'(m[1].running && m[1].lit));
        check("nibble_b0", 16'(nib1),  16'(m[1].nib));
        check("wrap_b0",   16'(wrap1), 16'(m[1].wrap));
    endtask

    initial begin
        int wq0 [$];
        int wq1 [$];
        int lit_cnt;
        bit found;
        bit md;
        bit st;
        logic [15:0] dg;

        rst = 1'b1; run = 1'b0; mode = 1'b0; step = 1'b0; digits = 16'h0;

        // Reset with random inputs
        repeat (2) tick(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        check("rst_x", 16'(x0), 16'd0);
        check("rst_en", 16'(en0), 16'd0);

        // Continuous scan, measure wrap period
        tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h4321);
        check("en_rise_1cyc", 16'(en0), 16'd1);
        check("first_nibble", 16'(nib0), 16'd1);
        repeat (60) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h4321);
            if (wrap0) wq0.push_back(cycle);
            if (wrap1) wq1.push_back(cycle);
        end
        check("wraps_seen_b2", 16'(wq0.size() >= 2), 16'd1);
        if (wq0.size() >= 2) check("period_b2", 16'(wq0[1] - wq0[0]), 16'd24);
        check("wraps_seen_b0", 16'(wq1.size() >= 2), 16'd1);
        if (wq1.size() >= 2) check("period_b0", 16'(wq1[1] - wq1[0]), 16'd16);

        // Single-step: two held presses give exactly two advances
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h4321);
        repeat (3) tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h4321);
        repeat (2) begin
            repeat (3) tick(1'b0, 1'b1, 1'b1, 1'b1, 16'h4321);
            repeat (5) tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h4321);
        end
        check("step_x_final", 16'(x0), 16'd2);
        check("step_en_held", 16'(en0), 16'd1);

        // Stop mid-count at x=2, then resume with a full count
        repeat (2) tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h4321);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h4321);
        check("stop_en", 16'(en0), 16'd0);
        check("stop_x", 16'(x0), 16'd2);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h4321);
        lit_cnt = 0;
        repeat (6) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h4321);
            if (en0 && x0 == 2'd2) lit_cnt++;
        end
        check("resume_full_div", 16'(lit_cnt), 16'd4);

        // Reset during the gap after x=3: no wrap pulse
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h4321);
            found = (m[0].idx == 3) && m[0].running && !m[0].lit;
        end
        check("blank_at_3_reached", 16'(found), 16'd1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 16'h4321);
        check("rst_blank_x", 16'(x0), 16'd0);
        check("rst_blank_wrap", 16'(wrap0), 16'd0);
        check("rst_blank_nib", 16'(nib0), 16'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h4321);
        check("post_rst_wrap", 16'(wrap0), 16'd0);

        // Random soak
        md = 1'b0;
        st = 1'b0;
        dg = 16'h4321;
        repeat (4000) begin
            if ($urandom_range(49) == 0) md = ~md;
            if ($urandom_range(2) == 0) st = ~st;
            if ($urandom_range(29) == 0) dg = 16'($urandom);
            tick(($urandom_range(199) == 0), ($urandom_range(19) != 0), md, st, dg);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
